// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: packet-engine state encoding and default widths.
package axis_pkg;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } axis_state_e;

endpackage

// File: rtl/axis_pkt_master_if.sv
// AXI-Stream beat bundle (payload, valid, last, ready) with master/slave views.
interface axis_pkt_master_if
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer: every output is a flop, and s_ready depends only on
// whether the skid entry is occupied, so downstream ready never reaches upstream.
module axis_reg_slice #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  logic [DATA_W-1:0] out_data_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] skid_data_p0;
  logic              skid_free_p0;
  logic              s_fire;
  logic              m_free;

  assign s_fire  = s_valid && skid_free_p0;
  assign m_free  = !vld_p1 || m_ready;
  assign s_ready = skid_free_p0;
  assign m_data  = out_data_p1;
  assign m_valid = vld_p1;

  // output stage: refill from skid first so beat order is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      skid_free_p0 <= 1'b1;
      out_data_p1  <= '0;
    end else if (m_free) begin
      if (!skid_free_p0) begin
        out_data_p1  <= skid_data_p0;
        vld_p1       <= 1'b1;
        skid_free_p0 <= 1'b1;
      end else begin
        vld_p1 <= s_fire;
        if (s_fire) out_data_p1 <= s_data;
      end
    end else if (s_fire) begin
      skid_free_p0 <= 1'b0;
    end
  end

  // skid stage: catches the beat that was in flight when the output stalled
  always_ff @(posedge clk) begin
    if (!m_free && s_fire) skid_data_p0 <= s_data;
  end

endmodule

// File: rtl/axis_pkt_master.sv
// Packet master: FSM, issue counter, pattern generator and source mux feeding
// a registered skid slice that drives the AXI-Stream output.
module axis_pkt_master
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int LEN_W  = AXIS_LEN_W
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_arst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              pattern_mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  axis_pkt_master_if.master m_axis,
  output logic              busy,
  output logic              pkt_done,
  output logic              len_err
);

  axis_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_p0;
  logic [LEN_W-1:0]  cnt_p0;
  logic              mode_p0;
  logic [DATA_W-1:0] pat_p0;
  logic              done_q;
  logic              err_q;

  logic              slice_rdy;
  logic              vld_p0;
  logic              last_p0;
  logic [DATA_W-1:0] beat_p0;
  logic              accept;
  logic              last_hs;
  logic [DATA_W:0]   slice_out;

  assign accept  = (state_q == IDLE) && start && (pkt_len != '0);
  assign last_hs = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  always_comb begin
    state_d = state_q;
    vld_p0  = 1'b0;
    beat_p0 = pat_p0;
    last_p0 = (cnt_p0 == (len_p0 - LEN_W'(1)));
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        vld_p0  = (mode_p0 || in_valid) && slice_rdy;
        beat_p0 = mode_p0 ? pat_p0 : data_in;
        if (vld_p0 && last_p0) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_arst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_p0  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && last_hs;
      err_q   <= (state_q == IDLE) && start && (pkt_len == '0);
      if (accept)      cnt_p0 <= '0;
      else if (vld_p0) cnt_p0 <= cnt_p0 + LEN_W'(1);
    end
  end

  // packet parameters and pattern generator (wraps modulo 2^DATA_W)
  always_ff @(posedge m_axis_aclk) begin
    if (accept) begin
      len_p0  <= pkt_len;
      mode_p0 <= pattern_mode;
      pat_p0  <= data_in;
    end else if (vld_p0) begin
      pat_p0  <= pat_p0 + DATA_W'(1);
    end
  end

  axis_reg_slice #(
    .DATA_W (DATA_W + 1)
  ) u_slice (
    .clk     (m_axis_aclk),
    .rst     (m_axis_arst),
    .s_data  ({last_p0, beat_p0}),
    .s_valid (vld_p0),
    .s_ready (slice_rdy),
    .m_data  (slice_out),
    .m_valid (m_axis.tvalid),
    .m_ready (m_axis.tready)
  );

  assign m_axis.tdata = slice_out[DATA_W-1:0];
  assign m_axis.tlast = slice_out[DATA_W];

  assign in_ready = (state_q == SEND) && !mode_p0 && slice_rdy;
  assign busy     = (state_q != IDLE);
  assign pkt_done = done_q;
  assign len_err  = err_q;

endmodule

// File: tb/tb_axis_pkt_master.sv
// Randomized bench for axis_pkt_master against a queue-based packet model.
module tb_axis_pkt_master;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam logic [6:0] TR_TBL = 7'b1101001;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] pkt_len;
  logic          pattern_mode;
  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          pkt_done;
  logic          len_err;

  axis_pkt_master_if #(.DATA_W(DW)) m_axis();

  axis_pkt_master #(.DATA_W(DW), .LEN_W(LW)) dut (
    .m_axis_aclk  (clk),
    .m_axis_arst  (rst),
    .start        (start),
    .pkt_len      (pkt_len),
    .pattern_mode (pattern_mode),
    .data_in      (data_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .m_axis       (m_axis),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // expected beats {tlast, tdata} of the packet in flight
  logic [8:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_beat;
  int         hs_cnt, first_hs, last_hs;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_tvalid", m_axis.tvalid, 1'b1);
        chk("stall_beat", {m_axis.tlast, m_axis.tdata}, prev_beat);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("beat", {m_axis.tlast, m_axis.tdata}, exp_q.pop_front());
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_beat  = {m_axis.tlast, m_axis.tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic tr(input int rmode, input int step);
    logic [6:0] tbl;
    tbl = TR_TBL;
    case (rmode)
      0:       return 1'b1;
      1:       return tbl[step % 7];
      2:       return ($urandom % 4) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; m_axis.tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // pass-through source beat k is seed + 0x11*k; pattern beat k is seed + k
  task automatic run_pkt(input bit pat, input int len, input logic [7:0] seed,
                         input int rmode, input bit gap, input bit poke);
    logic [7:0] src[$];
    int  src_idx, step, tmo;
    bit  up_acc, done;
    exp_q.delete();
    hs_cnt = 0; first_hs = -1; last_hs = -1;
    for (int k = 0; k < len; k++) begin
      if (pat) exp_q.push_back({k == len - 1, 8'(seed + k)});
      else begin
        src.push_back(8'(seed + 8'h11 * k));
        exp_q.push_back({k == len - 1, 8'(seed + 8'h11 * k)});
      end
    end
    if (!pat) src.push_back(8'(seed + 8'h11 * len));
    src_idx = 0;
    @(posedge clk); #1;
    start = 1'b1; pkt_len = LW'(len); pattern_mode = pat;
    data_in = pat ? seed : 8'(~seed); in_valid = 1'b0;
    m_axis.tready = tr(rmode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    if (!pat) begin
      in_valid = !gap || ($urandom % 2 == 0);
      data_in  = src[0];
    end
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    if (pat) chk("tvalid_lat0", m_axis.tvalid, 1'b0);
    step = 0; done = 1'b0; tmo = 8 * len + 100;
    while (tmo > 0) begin
      up_acc = in_valid && in_ready;
      done   = pkt_done;
      if (done) break;
      @(posedge clk); #1;
      step++;
      if (up_acc) src_idx++;
      if (!pat) begin
        if (!(in_valid && !up_acc))
          in_valid = (src_idx < src.size()) && (!gap || ($urandom % 2 == 0));
        data_in = (src_idx < src.size()) ? src[src_idx] : 8'h00;
      end
      m_axis.tready = tr(rmode, step);
      if (poke && step == 3) begin
        start = 1'b1; pkt_len = LW'(len + 5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (pat && step == 1) chk("tvalid_lat1", m_axis.tvalid, 1'b1);
      tmo--;
    end
    chk("pkt_done_seen", done, 1'b1);
    if (done) begin
      chk("done_busy", busy, 1'b0);
      chk("done_in_ready", in_ready, 1'b0);
      chk("done_tvalid", m_axis.tvalid, 1'b0);
      chk("done_latency", cyc - last_hs, 1);
      chk("beat_count", hs_cnt, len);
      chk("beats_left", exp_q.size(), 0);
      if (!pat) chk("src_consumed", src_idx, len);
      if (pat && rmode == 0) chk("back_to_back", last_hs - first_hs, len - 1);
      @(negedge clk);
      chk("done_pulse_width", pkt_done, 1'b0);
    end else begin
      mon_en = 1'b0;
      do_reset();
      exp_q.delete();
      mon_en = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pkt_len = '0; pattern_mode = 1'b0;
    data_in = '0; in_valid = 1'b0; m_axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tdata", m_axis.tdata, 8'h00);
    chk("rst_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_tlast", m_axis.tlast, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    run_pkt(1'b1, 4, 8'h10, 0, 1'b0, 1'b0);
    run_pkt(1'b1, 4, 8'h10, 1, 1'b0, 1'b0);
    run_pkt(1'b0, 3, 8'hAA, 2, 1'b1, 1'b0);

    @(posedge clk); #1;
    start = 1'b1; pkt_len = '0; pattern_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_err", len_err, 1'b1);
    chk("len0_busy", busy, 1'b0);
    @(negedge clk);
    chk("len0_err_pulse", len_err, 1'b0);
    chk("len0_tvalid", m_axis.tvalid, 1'b0);

    run_pkt(1'b1, 6, 8'h30, 0, 1'b0, 1'b1);
    run_pkt(1'b1, 4, 8'hFE, 2, 1'b0, 1'b0);
    run_pkt(1'b1, 255, 8'($urandom), 2, 1'b0, 1'b0);

    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pkt_len = 8'd8; pattern_mode = 1'b1; data_in = 8'h40; m_axis.tready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_tvalid", m_axis.tvalid, 1'b1);
    chk("pre_rst_tdata", m_axis.tdata, 8'h40);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_tdata", m_axis.tdata, 8'h00);
    chk("mid_rst_tvalid", m_axis.tvalid, 1'b0);
    chk("mid_rst_tlast", m_axis.tlast, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_pkt_done", pkt_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    run_pkt(1'b1, 2, 8'h55, 0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_pkt(1'($urandom % 2), $urandom_range(1, 20), 8'($urandom),
              $urandom_range(0, 2), 1'($urandom % 2), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
